// File: rtl/serial_pkg.sv
// Shared types for the serial transmitter: parity-mode encoding, FSM states
// and the parity helper used when a word is loaded into the shifter.
package serial_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    // Payload is zero-extended to 16 bits, which leaves its parity unchanged.
    function automatic logic parity_bit(input logic [15:0] word, input int mode);
        return (^word) ^ (mode == int'(ODD));
    endfunction

endpackage

// File: rtl/serial_shift_tx_baud_tick.sv
// Bit-period counter: tick is high in the last cycle of every line bit.
// tick_nx tells the FSM whether the following cycle will carry a tick.
module baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_nx
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    always_comb begin
        tick  = (cnt == LAST);
        cnt_n = cnt + 1'b1;
        if (clear || tick) begin
            cnt_n = '0;
        end
        tick_nx = (cnt_n == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

endmodule

// File: rtl/serial_shift_tx.sv
// Framed serial transmitter: one holding register in front of a shifter,
// start/data/parity/stop framing, registered line output.
module serial_shift_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e            state, state_n;
    logic [DATA_W-1:0] shifter, shifter_n;
    logic [DATA_W-1:0] hold, hold_n;
    logic              hold_full, hold_full_n;
    logic              pbit, pbit_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic              out_n, done_n, in_ready_n;
    logic              accept, load;
    logic              tick, tick_nx;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .tick   (tick),
        .tick_nx(tick_nx)
    );

    always_comb begin
        state_n     = state;
        shifter_n   = shifter;
        hold_n      = hold;
        hold_full_n = hold_full;
        pbit_n      = pbit;
        bitcnt_n    = bitcnt;
        done_n      = 1'b0;
        load        = 1'b0;
        out_n       = 1'b1;
        accept      = in_valid && in_ready;

        case (state)
            IDLE: begin
                load = accept;
            end
            START: begin
                if (tick) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == LAST_DATA) begin
                        state_n  = (PARITY != int'(NONE)) ? PAR : STOP;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n  = bitcnt + 1'b1;
                        shifter_n = shifter >> 1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_n  = STOP;
                    bitcnt_n = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bitcnt == LAST_STOP) begin
                        done_n   = 1'b1;
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        load     = hold_full || accept;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // The held word goes first; with nothing held, the word accepted this
        // cycle bypasses the holding register straight into the shifter.
        if (load) begin
            state_n  = START;
            bitcnt_n = '0;
            if (hold_full) begin
                shifter_n   = hold;
                hold_full_n = 1'b0;
            end else begin
                shifter_n = data_in;
            end
            pbit_n = parity_bit(16'(shifter_n), PARITY);
        end
        if (accept && !(load && !hold_full)) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
        end

        case (state_n)
            START:   out_n = 1'b0;
            DATA:    out_n = shifter_n[0];
            PAR:     out_n = pbit_n;
            default: out_n = 1'b1;
        endcase

        // Ready is also raised ahead of the final stop cycle so a new word can
        // land in the holding register while the held one drains.
        in_ready_n = !hold_full_n
                   || ((state_n == STOP) && (bitcnt_n == LAST_STOP) && tick_nx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            pbit      <= 1'b0;
            bitcnt    <= '0;
            out       <= 1'b1;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            shifter   <= shifter_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            pbit      <= pbit_n;
            bitcnt    <= bitcnt_n;
            out       <= out_n;
            done      <= done_n;
            in_ready  <= in_ready_n;
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Bench for serial_shift_tx: three parameter sets, each with a cycle-level
// line model built from frame rules, plus directed literal frame checks.
module tb_serial_shift_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_l;
    logic [2:0] in_valid;
    logic [7:0] din [3];
    wire  [2:0] out_s;
    wire  [2:0] busy_s;
    wire  [2:0] done_s;
    wire  [2:0] ready_s;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cfg0: 8N1, 1 clk/bit   cfg1: 8E1, 4 clk/bit   cfg2: 8O2, 1 clk/bit
    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int CK = (g == 1) ? 4 : 1;
        localparam int PM = g;
        localparam int SB = (g == 2) ? 2 : 1;

        serial_shift_tx #(
            .DATA_W      (8),
            .CLKS_PER_BIT(CK),
            .PARITY      (PM),
            .STOP_BITS   (SB)
        ) dut (
            .clk     (clk),
            .rst     (rst_l[g]),
            .data_in (din[g]),
            .in_valid(in_valid[g]),
            .in_ready(ready_s[g]),
            .out     (out_s[g]),
            .busy    (busy_s[g]),
            .done    (done_s[g])
        );

        bit lineq[$];   // expected line level for each upcoming cycle
        bit lastq[$];   // set on the final cycle of each frame
        int frames   = 0;
        bit done_e   = 1'b0;
        bit ready_ok = 1'b0;
        bit armed    = 1'b0;

        function automatic bit ready_e();
            return ready_ok && (frames < 2 || (frames == 2 && lastq[0]));
        endfunction

        always @(negedge clk) begin
            if (armed) begin
                check($sformatf("cfg%0d out", g), 32'(out_s[g]),
                      32'((lineq.size() > 0) ? lineq[0] : 1'b1));
                check($sformatf("cfg%0d busy", g), 32'(busy_s[g]), 32'(lineq.size() > 0));
                check($sformatf("cfg%0d done", g), 32'(done_s[g]), 32'(done_e));
                check($sformatf("cfg%0d in_ready", g), 32'(ready_s[g]), 32'(ready_e()));
            end
        end

        always @(posedge clk) begin : model
            bit acc;
            bit fb[$];
            int ones;
            if (!rst_l[g]) begin
                lineq.delete();
                lastq.delete();
                frames   = 0;
                done_e   = 1'b0;
                ready_ok = 1'b0;
                armed    = 1'b1;
            end else begin
                acc    = in_valid[g] && ready_e();
                done_e = 1'b0;
                if (lineq.size() > 0) begin
                    void'(lineq.pop_front());
                    if (lastq.pop_front()) begin
                        done_e = 1'b1;
                        frames--;
                    end
                end
                if (acc) begin
                    ones = $countones(din[g]);
                    fb.delete();
                    fb.push_back(1'b0);
                    for (int i = 0; i < 8; i++) fb.push_back(din[g][i]);
                    if (PM == 1) fb.push_back(ones % 2 == 1);
                    if (PM == 2) fb.push_back(ones % 2 == 0);
                    for (int s = 0; s < SB; s++) fb.push_back(1'b1);
                    foreach (fb[b]) begin
                        for (int c = 0; c < CK; c++) begin
                            lineq.push_back(fb[b]);
                            lastq.push_back(b == fb.size() - 1 && c == CK - 1);
                        end
                    end
                    frames++;
                end
                ready_ok = 1'b1;
            end
        end
    end

    logic [9:0]  e33;
    logic [10:0] e34;
    logic [11:0] e35;
    logic [7:0]  w3 [3];
    int          cnt, dones, sent, gap;
    logic        rdy;

    initial begin
        rst_l    = '0;
        in_valid = '0;
        foreach (din[i]) din[i] = '0;
        e33 = 10'b1101001010;       // 0xA5, 8N1
        e34 = 11'b11000001110;      // 0x07, even parity 1, 1 stop
        e35 = 12'b111000000000;     // 0x00, odd parity 1, 2 stops
        w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33;

        repeat (2) @(negedge clk);
        check("reset out", 32'(out_s), 32'(3'b111));
        check("reset busy", 32'(busy_s), 32'(3'b000));
        check("reset done", 32'(done_s), 32'(3'b000));
        check("reset in_ready", 32'(ready_s), 32'(3'b000));
        @(negedge clk);
        rst_l = '1;
        @(negedge clk);
        check("in_ready after release", 32'(ready_s), 32'(3'b111));

        // 0xA5 on 8N1
        din[0] = 8'hA5; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("a5 line", 32'(out_s[0]), 32'(e33[c]));
            check("a5 no early done", 32'(done_s[0]), 32'd0);
            @(negedge clk);
        end
        check("a5 idle line", 32'(out_s[0]), 32'd1);
        check("a5 done pulse", 32'(done_s[0]), 32'd1);
        check("a5 busy cleared", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        check("a5 done one cycle", 32'(done_s[0]), 32'd0);

        // 0x07, 4 clocks per bit, even parity
        din[1] = 8'h07; in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 44; c++) begin
            check("x07 line", 32'(out_s[1]), 32'(e34[c / 4]));
            cnt += int'(busy_s[1]);
            @(negedge clk);
        end
        check("x07 frame cycles", 32'(cnt), 32'd44);
        check("x07 done pulse", 32'(done_s[1]), 32'd1);
        check("x07 busy cleared", 32'(busy_s[1]), 32'd0);

        // 0x00, odd parity, two stop bits
        din[2] = 8'h00; in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            check("x00 line", 32'(out_s[2]), 32'(e35[c]));
            cnt += int'(busy_s[2]);
            @(negedge clk);
        end
        check("x00 frame bits", 32'(cnt), 32'd12);
        check("x00 done pulse", 32'(done_s[2]), 32'd1);

        // Three words with in_valid held high
        repeat (3) @(negedge clk);
        din[0] = w3[0]; in_valid[0] = 1'b1;
        rdy = ready_s[0];
        sent = 0; cnt = 0; dones = 0; gap = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (in_valid[0] && rdy) begin
                sent++;
                if (sent < 3) din[0] = w3[sent];
                else in_valid[0] = 1'b0;
            end
            rdy = ready_s[0];
            if (c == 1) check("b2b ready low while held", 32'(ready_s[0]), 32'd0);
            if (busy_s[0]) cnt++;
            else if (cnt > 0 && cnt < 30) gap++;
            dones += int'(done_s[0]);
        end
        check("b2b words accepted", 32'(sent), 32'd3);
        check("b2b busy cycles", 32'(cnt), 32'd30);
        check("b2b idle gaps", 32'(gap), 32'd0);
        check("b2b done pulses", 32'(dones), 32'd3);

        // Reset during data bit 3 with a second word held
        repeat (3) @(negedge clk);
        din[0] = 8'h5A; in_valid[0] = 1'b1;
        @(negedge clk);
        din[0] = 8'hC3;
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("abort word held", 32'(ready_s[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("abort data bit 3", 32'(out_s[0]), 32'd1);
        rst_l[0] = 1'b0;
        @(negedge clk);
        check("abort out", 32'(out_s[0]), 32'd1);
        check("abort busy", 32'(busy_s[0]), 32'd0);
        check("abort done", 32'(done_s[0]), 32'd0);
        check("abort in_ready", 32'(ready_s[0]), 32'd0);
        rst_l[0] = 1'b1;
        @(negedge clk);
        check("abort ready after release", 32'(ready_s[0]), 32'd1);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cnt += int'(busy_s[0]) + int'(done_s[0]) + int'(!out_s[0]);
            @(negedge clk);
        end
        check("abort no stale frame", 32'(cnt), 32'd0);

        // Random traffic with occasional resets, checked by the per-cycle model
        for (int c = 0; c < 2000; c++) begin
            for (int g = 0; g < 3; g++) begin
                in_valid[g] = ($urandom_range(0, 3) != 0);
                din[g]      = 8'($urandom);
                rst_l[g]    = ($urandom_range(0, 499) != 0);
            end
            @(negedge clk);
        end
        in_valid = '0;
        rst_l    = '1;
        repeat (100) @(negedge clk);
        check("drained busy", 32'(busy_s), 32'(3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_shift_tx.md
SERIAL_SHIFT_TX -- requirements
Module: serial_shift_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of payload bits per frame (range 5..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, clk cycles per line bit (range 1..65535).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port data_in  input  DATA_W  payload word, sampled on accept.
REQ-008 SHALL have port in_valid  input  1  producer offers data_in.
REQ-009 SHALL have port in_ready  output  1  a word can be accepted this cycle.
REQ-010 SHALL have port out  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame currently on the line.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last stop bit of each frame.

Function
REQ-013 SHALL accept a word on any cycle where in_valid and in_ready are both 1; nothing else accepts.
REQ-014 SHALL hold accepted words in a one-entry holding register plus the shifter, so up to two words are outstanding.
REQ-015 SHALL drive in_ready = holding register empty, registered; no combinational path from in_valid to in_ready.
REQ-016 SHALL send each frame as: start bit 0, DATA_W bits LSB first, optional parity bit, STOP_BITS bits of 1.
REQ-017 SHALL compute parity over the DATA_W payload bits: even mode makes total ones incl. parity even; odd mode makes it odd.
REQ-018 SHALL hold every line bit for exactly CLKS_PER_BIT cycles, using a baud counter that restarts at each bit boundary.
REQ-019 SHALL use FSM states IDLE, START, DATA, PAR, STOP; IDLE->START on holding-register load; START->DATA; DATA->PAR (PARITY!=0) or STOP after bit DATA_W-1; PAR->STOP; STOP->START if holding register full, else IDLE.
REQ-020 SHALL drive out as a registered output; its first start-bit cycle is the cycle after the accepting edge when idle (latency 1).
REQ-021 SHALL start the next frame start bit on the cycle immediately after the last stop-bit cycle when a word is held (no idle gap).
REQ-022 SHALL accept a new word in the same cycle that the holding register transfers to the shifter (simultaneous drain and fill).
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL pulse done for exactly one cycle, in the cycle after the final stop-bit cycle, concurrent with IDLE or the next START.
REQ-025 SHALL ignore data_in changes after acceptance; the shifted word is the value captured at accept.
REQ-026 SHALL count bits with a counter of width clog2(DATA_W+1) and baud with width clog2(CLKS_PER_BIT+1); neither wraps inside a frame.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, set out=1, busy=0, done=0, in_ready=0, state IDLE, counters 0, holding register empty.
REQ-028 SHALL raise in_ready on the first edge after rst returns to 1.
REQ-029 SHALL abort any frame in progress on reset mid-frame, discard both held words and emit no done for the aborted frame.

Structure
REQ-030 SHALL take the parity-mode encoding (NONE/EVEN/ODD) and FSM state enum from shared package serial_pkg.
REQ-031 SHALL instantiate one sub-module baud_tick (counter emitting a one-cycle tick every CLKS_PER_BIT cycles, cleared at frame start).
REQ-032 SHALL contain the FSM, holding register, shifter and parity logic in serial_shift_tx itself.

Verification
REQ-033 Bench SHALL check: DATA_W=8, CLKS_PER_BIT=1, PARITY=0; send 0xA5 -> out = 0,1,0,1,0,0,1,0,1,1 then idle 1; done one cycle after last stop bit.
REQ-034 Bench SHALL check: CLKS_PER_BIT=4, PARITY=1, send 0x07 -> each bit held 4 cycles; parity bit 1; frame is 44 cycles.
REQ-035 Bench SHALL check: PARITY=2, STOP_BITS=2, send 0x00 -> parity bit 1, two stop bits, frame is 12 bit-times.
REQ-036 Bench SHALL check: in_valid held high with 0x11,0x22,0x33 -> three back-to-back frames with no idle cycle; in_ready low while holding register full.
REQ-037 Bench SHALL check: rst=0 during data bit 3 of a frame with a word held -> next edge out=1, busy=0, no done; after release, in_ready=1 and no stale frame is sent.
